// File: rtl/axi_wr_upsizer_pkg.sv
// ---------------------------------------------------------------------------
// axiDemo_package
// Shared AXI widths, bus typedefs and the upsizer state encoding.
// Imported by axi_wr_lane_merge and axi_wr_upsizer.
// ---------------------------------------------------------------------------
package axiDemo_package;

  localparam int AXI_ADDRESS_WIDTH     = 32;
  localparam int AXI_DATA_WIDTH        = 32;
  localparam int AXI_STROBE_WIDTH      = AXI_DATA_WIDTH / 8;
  localparam int AXI_WIDE_DATA_WIDTH   = 128;
  localparam int AXI_WIDE_STROBE_WIDTH = 16;

  typedef logic [AXI_ADDRESS_WIDTH-1:0]     axiAddrT;
  typedef logic [AXI_DATA_WIDTH-1:0]        axiDataT;
  typedef logic [AXI_STROBE_WIDTH-1:0]      axiStrobeT;
  typedef logic [AXI_WIDE_DATA_WIDTH-1:0]   axiWideDataT;
  typedef logic [AXI_WIDE_STROBE_WIDTH-1:0] axiWideStrobeT;

  typedef struct packed {
    axiWideDataT   data;
    axiWideStrobeT strb;
  } axiWideDataSt;

  typedef enum logic [1:0] {
    UPSZ_EMPTY   = 2'd0,
    UPSZ_PARTIAL = 2'd1,
    UPSZ_FULL    = 2'd2
  } upszStateT;

endpackage

// File: rtl/axi_wr_upsizer_lane_merge.sv
// ---------------------------------------------------------------------------
// axi_wr_lane_merge
// Combinational byte-enable merge of one narrow beat into a wide accumulator.
// Ports:
//   i_acc_data/i_acc_strb : current accumulator contents (already cleared by
//                           the caller when the wide beat has just left)
//   i_en                  : narrow beat accepted this cycle
//   i_lane                : lane index the narrow beat lands in
//   i_in_data/i_in_strb   : narrow beat payload
//   o_data/o_strb         : accumulator contents after the merge
// ---------------------------------------------------------------------------
module axi_wr_lane_merge
  import axiDemo_package::*;
#(
  parameter int IN_DATA_WIDTH  = AXI_DATA_WIDTH,
  parameter int OUT_DATA_WIDTH = AXI_WIDE_DATA_WIDTH,
  parameter int LW             = 2
) (
  input  logic [OUT_DATA_WIDTH-1:0]   i_acc_data,
  input  logic [OUT_DATA_WIDTH/8-1:0] i_acc_strb,
  input  logic                        i_en,
  input  logic [LW-1:0]               i_lane,
  input  logic [IN_DATA_WIDTH-1:0]    i_in_data,
  input  logic [IN_DATA_WIDTH/8-1:0]  i_in_strb,
  output logic [OUT_DATA_WIDTH-1:0]   o_data,
  output logic [OUT_DATA_WIDTH/8-1:0] o_strb
);

  localparam int IN_BYTES = IN_DATA_WIDTH / 8;

  // Only strobed bytes are written, so a repeated lane keeps its unstrobed
  // bytes from the earlier write.
  always_comb begin
    o_data = i_acc_data;
    o_strb = i_acc_strb;
    if (i_en) begin
      for (int b = 0; b < IN_BYTES; b++) begin
        if (i_in_strb[b]) begin
          o_data[int'(i_lane)*IN_DATA_WIDTH + b*8 +: 8] = i_in_data[b*8 +: 8];
          o_strb[int'(i_lane)*IN_BYTES + b]             = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/axi_wr_upsizer.sv
// ---------------------------------------------------------------------------
// axi_wr_upsizer
// Packs narrow AXI write beats into wide beats (RATIO = OUT/IN lanes).
// Ports:
//   clk, rst_n                      : clock, async active-low reset
//   in_valid/in_ready               : narrow handshake
//   in_addr/in_data/in_strb/in_last : narrow payload
//   out_valid/out_ready             : wide handshake
//   out_addr/out_data/out_strb/out_last : wide payload
// Build option:
//   AXI_WR_UPSIZER_ADDR_FLUSH_EN : flush a partial wide beat when the next
//                                  narrow beat falls in a different wide word.
//
// state   | meaning
// EMPTY   | no data held
// PARTIAL | accumulating lanes, out_valid low
// FULL    | wide beat presented, waiting for out_ready
// ---------------------------------------------------------------------------
module axi_wr_upsizer
  import axiDemo_package::*;
#(
  parameter int ADDR_WIDTH     = AXI_ADDRESS_WIDTH,
  parameter int IN_DATA_WIDTH  = AXI_DATA_WIDTH,
  parameter int OUT_DATA_WIDTH = AXI_WIDE_DATA_WIDTH
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [ADDR_WIDTH-1:0]       in_addr,
  input  logic [IN_DATA_WIDTH-1:0]    in_data,
  input  logic [IN_DATA_WIDTH/8-1:0]  in_strb,
  input  logic                        in_last,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [ADDR_WIDTH-1:0]       out_addr,
  output logic [OUT_DATA_WIDTH-1:0]   out_data,
  output logic [OUT_DATA_WIDTH/8-1:0] out_strb,
  output logic                        out_last
);

  localparam int RATIO     = OUT_DATA_WIDTH / IN_DATA_WIDTH;
  localparam int IN_BYTES  = IN_DATA_WIDTH / 8;
  localparam int OUT_BYTES = OUT_DATA_WIDTH / 8;
  localparam int IB        = $clog2(IN_BYTES);
  localparam int OB        = $clog2(OUT_BYTES);
  localparam int LW        = $clog2(RATIO);
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(OUT_BYTES - 1);
  localparam logic [LW-1:0]         LANE_MAX   = LW'(RATIO - 1);

  upszStateT                   r_state, w_state_nxt;
  logic [OUT_DATA_WIDTH-1:0]   r_data, w_base_data, w_merged_data;
  logic [OUT_BYTES-1:0]        r_strb, w_base_strb, w_merged_strb;
  logic [ADDR_WIDTH-1:0]       r_addr;
  logic                        r_last;

  logic [LW-1:0]               w_lane;
  logic [ADDR_WIDTH-1:0]       w_in_aligned;
  logic                        w_out_fire, w_in_fire, w_completes, w_fresh, w_flush;

  assign w_lane       = in_addr[OB-1:IB];
  assign w_in_aligned = in_addr & ALIGN_MASK;
  assign w_completes  = (w_lane == LANE_MAX) || in_last;
  assign w_out_fire   = (r_state == UPSZ_FULL) && out_ready;
  assign w_in_fire    = in_valid && in_ready;
  // A beat accepted while EMPTY, or in the same cycle the wide beat leaves,
  // opens a new wide word and owns out_addr.
  assign w_fresh      = (r_state == UPSZ_EMPTY) || w_out_fire;

`ifdef AXI_WR_UPSIZER_ADDR_FLUSH_EN
  assign w_flush = (r_state == UPSZ_PARTIAL) && in_valid && (w_in_aligned != r_addr);
`else
  assign w_flush = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= UPSZ_EMPTY;
    else        r_state <= w_state_nxt;
  end

  // Next-state
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      UPSZ_EMPTY, UPSZ_PARTIAL: begin
        if (w_flush)        w_state_nxt = UPSZ_FULL;
        else if (w_in_fire) w_state_nxt = w_completes ? UPSZ_FULL : UPSZ_PARTIAL;
      end
      UPSZ_FULL: begin
        if (out_ready) begin
          if (w_in_fire) w_state_nxt = w_completes ? UPSZ_FULL : UPSZ_PARTIAL;
          else           w_state_nxt = UPSZ_EMPTY;
        end
      end
      default: w_state_nxt = UPSZ_EMPTY;
    endcase
  end

  // Outputs
  always_comb begin
    out_valid = (r_state == UPSZ_FULL);
    in_ready  = ((r_state != UPSZ_FULL) || out_ready) && !w_flush;
  end

  assign w_base_data = w_out_fire ? '0 : r_data;
  assign w_base_strb = w_out_fire ? '0 : r_strb;

  axi_wr_lane_merge #(
    .IN_DATA_WIDTH  (IN_DATA_WIDTH),
    .OUT_DATA_WIDTH (OUT_DATA_WIDTH),
    .LW             (LW)
  ) u_merge (
    .i_acc_data (w_base_data),
    .i_acc_strb (w_base_strb),
    .i_en       (w_in_fire),
    .i_lane     (w_lane),
    .i_in_data  (in_data),
    .i_in_strb  (in_strb),
    .o_data     (w_merged_data),
    .o_strb     (w_merged_strb)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data <= '0;
      r_strb <= '0;
      r_addr <= '0;
      r_last <= 1'b0;
    end else begin
      r_data <= w_merged_data;
      r_strb <= w_merged_strb;
      if (w_in_fire && w_fresh) r_addr <= w_in_aligned;
      // A flushed word is never the end of a burst.
      if (w_flush)                      r_last <= 1'b0;
      else if (w_in_fire && w_completes) r_last <= in_last;
      else if (w_out_fire)               r_last <= 1'b0;
    end
  end

  assign out_addr = r_addr;
  assign out_data = r_data;
  assign out_strb = r_strb;
  assign out_last = r_last;

endmodule

// File: tb/tb_axi_wr_upsizer.sv
module tb_axi_wr_upsizer;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [31:0]  in_addr = '0;
  logic [31:0]  in_data = '0;
  logic [3:0]   in_strb = '0;
  logic         in_last = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [31:0]  out_addr;
  logic [127:0] out_data;
  logic [15:0]  out_strb;
  logic         out_last;

  int checks = 0;
  int errors = 0;
  int fires  = 0;

  typedef struct {
    logic [31:0]  addr;
    logic [127:0] data;
    logic [15:0]  strb;
    logic         last;
  } wbeat_t;

  wbeat_t      exp_q[$];
  wbeat_t      last_fire;
  logic [7:0]  acc_bytes [16];
  logic [15:0] acc_strb = '0;
  logic [31:0] acc_addr = '0;
  bit          acc_active = 1'b0;

  always #5 clk = ~clk;

  axi_wr_upsizer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_addr   (in_addr),
    .in_data   (in_data),
    .in_strb   (in_strb),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_addr  (out_addr),
    .out_data  (out_data),
    .out_strb  (out_strb),
    .out_last  (out_last)
  );

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] pack_acc();
    logic [127:0] d;
    for (int i = 0; i < 16; i++) d[i*8 +: 8] = acc_bytes[i];
    return d;
  endfunction

  // Transaction-level model: narrow beats gather into a 16-byte word keyed by
  // the first beat's 16-byte-aligned address; the word is due one cycle after
  // the beat that fills lane 3 or carries last.
  always @(negedge clk) begin : mon
    logic [31:0] al;
    logic        flush_now;
    logic        exp_rdy;
    int          lane;
    wbeat_t      b;
    if (!rst_n) begin
      exp_q.delete();
      acc_active = 1'b0;
    end else begin
      al        = in_addr & 32'hFFFF_FFF0;
      flush_now = 1'b0;
`ifdef AXI_WR_UPSIZER_ADDR_FLUSH_EN
      flush_now = in_valid && acc_active && (al != acc_addr);
`endif
      exp_rdy = ((exp_q.size() == 0) || out_ready) && !flush_now;
      chk("in_ready", 128'(in_ready), 128'(exp_rdy));
      chk("out_valid", 128'(out_valid), 128'(exp_q.size() != 0));
      if (out_valid && exp_q.size() != 0) begin
        chk("out_addr", 128'(out_addr), 128'(exp_q[0].addr));
        chk("out_data", out_data, exp_q[0].data);
        chk("out_strb", 128'(out_strb), 128'(exp_q[0].strb));
        chk("out_last", 128'(out_last), 128'(exp_q[0].last));
        if (out_ready) begin
          last_fire = exp_q.pop_front();
          fires++;
        end
      end
      if (flush_now) begin
        b.addr = acc_addr; b.data = pack_acc(); b.strb = acc_strb; b.last = 1'b0;
        exp_q.push_back(b);
        acc_active = 1'b0;
      end else if (in_valid && in_ready) begin
        if (!acc_active) begin
          acc_addr = al;
          acc_strb = '0;
          for (int i = 0; i < 16; i++) acc_bytes[i] = 8'h00;
          acc_active = 1'b1;
        end
        lane = int'(in_addr[3:2]);
        for (int k = 0; k < 4; k++) begin
          if (in_strb[k]) begin
            acc_bytes[lane*4 + k] = in_data[k*8 +: 8];
            acc_strb[lane*4 + k]  = 1'b1;
          end
        end
        if (lane == 3 || in_last) begin
          b.addr = acc_addr; b.data = pack_acc(); b.strb = acc_strb; b.last = in_last;
          exp_q.push_back(b);
          acc_active = 1'b0;
        end
      end
    end
  end

  task automatic send(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                      input logic l, output int waited);
    logic ok;
    waited   = 0;
    ok       = 1'b0;
    in_valid = 1'b1; in_addr = a; in_data = d; in_strb = s; in_last = l;
    while (!ok && waited < 50) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
      waited++;
    end
    in_valid = 1'b0;
    if (!ok) chk("send_timeout", 128'(0), 128'(1));
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk_fire(input string tag, input logic [31:0] a, input logic [127:0] d,
                          input logic [15:0] s, input logic l);
    chk({tag, "_addr"}, 128'(last_fire.addr), 128'(a));
    chk({tag, "_data"}, last_fire.data, d);
    chk({tag, "_strb"}, 128'(last_fire.strb), 128'(s));
    chk({tag, "_last"}, 128'(last_fire.last), 128'(l));
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int f0;
    #2;
    chk("rst_out_valid", 128'(out_valid), 128'(0));
    chk("rst_out_data", out_data, 128'(0));
    chk("rst_out_strb", 128'(out_strb), 128'(0));
    chk("rst_out_addr", 128'(out_addr), 128'(0));
    chk("rst_out_last", 128'(out_last), 128'(0));
    @(posedge clk); #1; rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", 128'(in_ready), 128'(1));
    @(posedge clk); #1;

    // Full 4-beat word
    f0 = fires;
    send(32'h100, 32'h11111111, 4'hF, 1'b0, n);
    send(32'h104, 32'h22222222, 4'hF, 1'b0, n);
    send(32'h108, 32'h33333333, 4'hF, 1'b0, n);
    send(32'h10C, 32'h44444444, 4'hF, 1'b1, n);
    chk("s1_latency_valid", 128'(out_valid), 128'(1));
    idle(3);
    chk("s1_fires", 128'(fires - f0), 128'(1));
    chk_fire("s1", 32'h100, 128'h44444444_33333333_22222222_11111111, 16'hFFFF, 1'b1);

    // Upper half only
    f0 = fires;
    send(32'h108, 32'hCAFEF00D, 4'hF, 1'b0, n);
    send(32'h10C, 32'h01234567, 4'hF, 1'b1, n);
    idle(3);
    chk("s2_fires", 128'(fires - f0), 128'(1));
    chk_fire("s2", 32'h100, 128'h01234567_CAFEF00D_00000000_00000000, 16'hFF00, 1'b1);

    // Early last, then a new word at 0x110
    f0 = fires;
    send(32'h100, 32'hAAAA5555, 4'hF, 1'b0, n);
    send(32'h104, 32'h5555AAAA, 4'hF, 1'b1, n);
    idle(2);
    chk_fire("s3a", 32'h100, 128'h00000000_00000000_5555AAAA_AAAA5555, 16'h00FF, 1'b1);
    send(32'h110, 32'h0F0F0F0F, 4'hF, 1'b1, n);
    idle(3);
    chk("s3_fires", 128'(fires - f0), 128'(2));
    chk_fire("s3b", 32'h110, 128'h0F0F0F0F, 16'h000F, 1'b1);

    // Backpressure while FULL
    out_ready = 1'b0;
    send(32'h100, 32'h0A0A0A0A, 4'hF, 1'b0, n);
    send(32'h104, 32'h0B0B0B0B, 4'hF, 1'b0, n);
    send(32'h108, 32'h0C0C0C0C, 4'hF, 1'b0, n);
    send(32'h10C, 32'h0D0D0D0D, 4'hF, 1'b0, n);
    in_valid = 1'b1; in_addr = 32'h200; in_data = 32'h55555555; in_strb = 4'hF; in_last = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("s4_stall_in_ready", 128'(in_ready), 128'(0));
      chk("s4_hold_data", out_data, 128'h0D0D0D0D_0C0C0C0C_0B0B0B0B_0A0A0A0A);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    send(32'h200, 32'h55555555, 4'hF, 1'b0, n);
    chk("s4_accept_wait", 128'(n), 128'(1));
    chk_fire("s4a", 32'h100, 128'h0D0D0D0D_0C0C0C0C_0B0B0B0B_0A0A0A0A, 16'hFFFF, 1'b0);
    chk("s4_clear_valid", 128'(out_valid), 128'(0));
    chk("s4_clear_strb", 128'(out_strb), 128'(16'h000F));
    chk("s4_clear_data", out_data, 128'h55555555);
    chk("s4_new_addr", 128'(out_addr), 128'(32'h200));
    send(32'h20C, 32'h66666666, 4'hF, 1'b1, n);
    idle(3);
    chk_fire("s4b", 32'h200, 128'h66666666_00000000_00000000_55555555, 16'hF00F, 1'b1);

    // Address jump to another wide word
    send(32'h100, 32'h77777777, 4'hF, 1'b0, n);
    send(32'h204, 32'h88888888, 4'hF, 1'b0, n);
`ifdef AXI_WR_UPSIZER_ADDR_FLUSH_EN
    chk("s5_stall_cycles", 128'(n), 128'(2));
    chk_fire("s5a", 32'h100, 128'h77777777, 16'h000F, 1'b0);
    chk("s5_partial_addr", 128'(out_addr), 128'(32'h200));
    chk("s5_partial_strb", 128'(out_strb), 128'(16'h00F0));
`else
    chk("s5_stall_cycles", 128'(n), 128'(1));
    chk("s5_partial_addr", 128'(out_addr), 128'(32'h100));
    chk("s5_partial_strb", 128'(out_strb), 128'(16'h00FF));
`endif
    chk("s5_partial_valid", 128'(out_valid), 128'(0));
    send(32'h20C, 32'h99999999, 4'hF, 1'b1, n);
    idle(3);
`ifdef AXI_WR_UPSIZER_ADDR_FLUSH_EN
    chk_fire("s5b", 32'h200, 128'h99999999_00000000_88888888_00000000, 16'hF0F0, 1'b1);
`else
    chk_fire("s5b", 32'h100, 128'h99999999_00000000_88888888_77777777, 16'hF0FF, 1'b1);
`endif

    // Reset in the middle of an accumulation
    send(32'h100, 32'h12121212, 4'hF, 1'b0, n);
    send(32'h104, 32'h34343434, 4'hF, 1'b0, n);
    chk("s6_pre_strb", 128'(out_strb), 128'(16'h00FF));
    #3 rst_n = 1'b0;
    #1;
    chk("s6_rst_valid", 128'(out_valid), 128'(0));
    chk("s6_rst_data", out_data, 128'(0));
    chk("s6_rst_strb", 128'(out_strb), 128'(0));
    chk("s6_rst_addr", 128'(out_addr), 128'(0));
    chk("s6_rst_last", 128'(out_last), 128'(0));
    @(negedge clk);
    @(posedge clk); #2 rst_n = 1'b1;
    f0 = fires;
    idle(6);
    chk("s6_no_emit", 128'(fires - f0), 128'(0));

    // Repeated lane and sparse strobes
    f0 = fires;
    send(32'h100, 32'hAAAAAAAA, 4'hF, 1'b0, n);
    send(32'h100, 32'h12345678, 4'h3, 1'b0, n);
    send(32'h10C, 32'hDEADBEEF, 4'h8, 1'b1, n);
    idle(3);
    chk("s7_fires", 128'(fires - f0), 128'(1));
    chk_fire("s7", 32'h100, 128'hDE000000_00000000_00000000_AAAA5678, 16'h800F, 1'b1);

    idle(3);
    chk("drain", 128'(exp_q.size()), 128'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
